algo_mrpnwp_wr_sched: RTL

// Write-port scheduler in front of the multi-read/multi-write banked 1R1W memory core.

---
 rtl/algo_mrpnwp_wr_sched_if.sv | 38 +++
 rtl/algo_mrpnwp_wr_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/algo_mrpnwp_wr_sched_if.sv
// Request/issue bundle for the write-port scheduler.
//   mem_ready           core ready (driven by the memory side)
//   req_vld/rdy         per-port request handshake
//   req_badr/radr/din   per-port bank address, row address, write data
//   write               issued write strobe per slot
//   wr_badr/radr, din   issued bank address, row address, data per slot
//   req_err             accepted request had an out-of-range bank
//   ready               scheduler accepting traffic
// Modports: slave = scheduler view, master = requester/memory/bench view.
interface algo_mrpnwp_wr_sched_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUMWRPT = 3,
  parameter int unsigned BITVBNK = 3,
  parameter int unsigned BITVROW = 10
);
  logic                       mem_ready;
  logic [NUMWRPT-1:0]         req_vld;
  logic [NUMWRPT-1:0]         req_rdy;
  logic [NUMWRPT*BITVBNK-1:0] req_badr;
  logic [NUMWRPT*BITVROW-1:0] req_radr;
  logic [NUMWRPT*WIDTH-1:0]   req_din;
  logic [NUMWRPT-1:0]         write;
  logic [NUMWRPT*BITVBNK-1:0] wr_badr;
  logic [NUMWRPT*BITVROW-1:0] wr_radr;
  logic [NUMWRPT*WIDTH-1:0]   din;
  logic [NUMWRPT-1:0]         req_err;
  logic                       ready;

  modport slave (
    input  mem_ready, req_vld, req_badr, req_radr, req_din,
    output req_rdy, write, wr_badr, wr_radr, din, req_err, ready
  );

  modport master (
    output mem_ready, req_vld, req_badr, req_radr, req_din,
    input  req_rdy, write, wr_badr, wr_radr, din, req_err, ready
  );
endinterface

// File: rtl/algo_mrpnwp_wr_sched.sv
// Write-port scheduler in front of the banked 1R1W memory core.
// Accepts NUMWRPT write requests per cycle and issues at most one write per bank,
// arbitrating bank conflicts round-robin. Issued writes appear one cycle after the grant,
// in the slot equal to the requesting port index.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   algo_mrpnwp_wr_sched_if.slave (request handshake, issued writes, req_err, ready)
// Build option: define MRPNWP_WRSCHED_INIT_EN to zero-fill every row of every bank after reset
// before ready rises; otherwise INIT ends on the first cycle with mem_ready high.
module algo_mrpnwp_wr_sched #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUMWRPT = 3,
  parameter int unsigned NUMVBNK = 8,
  parameter int unsigned BITVBNK = 3,
  parameter int unsigned NUMVROW = 1024,
  parameter int unsigned BITVROW = 10
) (
  input logic                  clk,
  input logic                  rst,
  algo_mrpnwp_wr_sched_if.slave bus
);
  localparam int unsigned PtrW       = (NUMWRPT > 1) ? $clog2(NUMWRPT) : 1;
  localparam int unsigned SumW       = PtrW + 1;
  localparam int unsigned NumBankIdx = 1 << BITVBNK;

  if (NUMWRPT < 2 || NUMVBNK < 1 || NUMVROW < 1 || NumBankIdx < NUMVBNK) begin : g_param_check
    $error("algo_mrpnwp_wr_sched: invalid parameter set");
  end

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                     state_q, state_d;
  logic [PtrW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [NUMWRPT-1:0]         write_q, write_d;
  logic [NUMWRPT-1:0]         req_err_q, req_err_d;
  logic [NUMWRPT*BITVBNK-1:0] wr_badr_q, wr_badr_d;
  logic [NUMWRPT*BITVROW-1:0] wr_radr_q, wr_radr_d;
  logic [NUMWRPT*WIDTH-1:0]   din_q, din_d;
  logic                       ready_q;

`ifdef MRPNWP_WRSCHED_INIT_EN
  localparam int unsigned NumGrp = (NUMVBNK + NUMWRPT - 1) / NUMWRPT;
  localparam int unsigned GrpW   = (NumGrp > 1) ? $clog2(NumGrp) : 1;
  logic [BITVROW-1:0] row_q, row_d;
  logic [GrpW-1:0]    grp_q, grp_d;
  // Set once the last group of the last row is issued; RUN follows on the next edge.
  logic               sweep_done_q, sweep_done_d;
`endif

  logic [BITVBNK-1:0]    badr [NUMWRPT];
  logic [NUMWRPT-1:0]    oob;
  logic [NUMWRPT-1:0]    gnt;
  logic [NumBankIdx-1:0] claimed;
  logic                  denied;

  always_comb begin
    for (int i = 0; i < NUMWRPT; i++) begin
      badr[i] = bus.req_badr[i*BITVBNK +: BITVBNK];
      oob[i]  = 32'(badr[i]) >= NUMVBNK;
    end
  end

  // Round-robin visit starting at rr_ptr; the first visited port claims a bank.
  // Out-of-range requests are always taken and claim nothing.
  always_comb begin
    logic [SumW-1:0] sum;
    logic [PtrW-1:0] p;
    gnt     = '0;
    claimed = '0;
    denied  = 1'b0;
    sum     = '0;
    p       = '0;
    if (state_q == StRun && bus.mem_ready) begin
      for (int k = 0; k < NUMWRPT; k++) begin
        sum = {1'b0, rr_ptr_q} + SumW'(k);
        if (sum >= SumW'(NUMWRPT)) sum = sum - SumW'(NUMWRPT);
        p = sum[PtrW-1:0];
        if (bus.req_vld[p]) begin
          if (oob[p]) begin
            gnt[p] = 1'b1;
          end else if (!claimed[badr[p]]) begin
            gnt[p]             = 1'b1;
            claimed[badr[p]]   = 1'b1;
          end else begin
            denied = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (denied) rr_ptr_d = (rr_ptr_q == PtrW'(NUMWRPT - 1)) ? '0 : rr_ptr_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    write_d   = '0;
    req_err_d = '0;
    wr_badr_d = wr_badr_q;
    wr_radr_d = wr_radr_q;
    din_d     = din_q;
`ifdef MRPNWP_WRSCHED_INIT_EN
    row_d        = row_q;
    grp_d        = grp_q;
    sweep_done_d = sweep_done_q;
`endif
    unique case (state_q)
      StInit: begin
`ifdef MRPNWP_WRSCHED_INIT_EN
        if (sweep_done_q) begin
          state_d = StRun;
        end else if (bus.mem_ready) begin
          for (int i = 0; i < NUMWRPT; i++) begin
            int unsigned bank;
            bank = 32'(grp_q) * NUMWRPT + 32'(i);
            write_d[i]                      = bank < NUMVBNK;
            wr_badr_d[i*BITVBNK +: BITVBNK] = BITVBNK'(bank);
            wr_radr_d[i*BITVROW +: BITVROW] = row_q;
            din_d[i*WIDTH +: WIDTH]         = '0;
          end
          if (grp_q == GrpW'(NumGrp - 1)) begin
            grp_d = '0;
            if (row_q == BITVROW'(NUMVROW - 1)) sweep_done_d = 1'b1;
            else                                row_d        = row_q + 1'b1;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
`else
        if (bus.mem_ready) state_d = StRun;
`endif
      end
      StRun: begin
        for (int p = 0; p < NUMWRPT; p++) begin
          if (gnt[p]) begin
            if (oob[p]) begin
              req_err_d[p] = 1'b1;
            end else begin
              write_d[p]                      = 1'b1;
              wr_badr_d[p*BITVBNK +: BITVBNK] = badr[p];
              wr_radr_d[p*BITVROW +: BITVROW] = bus.req_radr[p*BITVROW +: BITVROW];
              din_d[p*WIDTH +: WIDTH]         = bus.req_din[p*WIDTH +: WIDTH];
            end
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StInit;
      rr_ptr_q  <= '0;
      write_q   <= '0;
      req_err_q <= '0;
      wr_badr_q <= '0;
      wr_radr_q <= '0;
      din_q     <= '0;
      ready_q   <= 1'b0;
`ifdef MRPNWP_WRSCHED_INIT_EN
      row_q        <= '0;
      grp_q        <= '0;
      sweep_done_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      write_q   <= write_d;
      req_err_q <= req_err_d;
      wr_badr_q <= wr_badr_d;
      wr_radr_q <= wr_radr_d;
      din_q     <= din_d;
      ready_q   <= (state_d == StRun);
`ifdef MRPNWP_WRSCHED_INIT_EN
      row_q        <= row_d;
      grp_q        <= grp_d;
      sweep_done_q <= sweep_done_d;
`endif
    end
  end

  assign bus.req_rdy = gnt;
  assign bus.write   = write_q;
  assign bus.req_err = req_err_q;
  assign bus.wr_badr = wr_badr_q;
  assign bus.wr_radr = wr_radr_q;
  assign bus.din     = din_q;
  assign bus.ready   = ready_q;
endmodule
